// File: rtl/sseg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display: drives the
// segment-mux select, the active-low anodes with a dead-time gap, and slot/frame ticks.
module sseg_scan_ctrl #(
    parameter int DIV  = 100000,
    parameter int DEAD = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] blank,
    output logic [2:0] sel,
    output logic [7:0] an,
    output logic       slot_tick,
    output logic       frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          in_dead;
    logic          active;
    logic          slot_end;

    // With no dead time the comparison would be constant, so it is elided.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt < CW'(DEAD));
        end
    endgenerate

    assign active   = (state == SCAN) && en;
    assign slot_end = active && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            an         <= 8'hFF;
            slot_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            slot_tick  <= slot_end;
            frame_tick <= slot_end && (sel == 3'd7);
            an         <= (active && !in_dead && !blank[sel]) ? ~(8'b1 << sel) : 8'hFF;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // Dropping en restarts the current digit's slot rather than skipping it.
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (slot_end) begin
                        cnt <= '0;
                        sel <= sel + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_an_onehot_low: assert property (@(posedge clk) disable iff (reset) $onehot0(~an));

endmodule
